// File: rtl/volume_meter_ctrl_if.sv
// Sample strobe in, meter level/peak/clip out, between codec and bar display.
interface volume_meter_ctrl_if #(
  parameter int SAMPLE_W = 24
);
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] level_out;
  logic [SAMPLE_W-1:0] peak_out;
  logic                clip_out;
  logic                level_valid;

  modport master (
    output sample_valid, sample,
    input  level_out, peak_out, clip_out, level_valid
  );

  modport slave (
    input  sample_valid, sample,
    output level_out, peak_out, clip_out, level_valid
  );
endinterface

// File: rtl/volume_meter_ctrl.sv
// Windowed peak meter: per-window max magnitude, then fast attack / exponential
// decay of the level, a held peak and a clip flag, published once per window.
module volume_meter_ctrl #(
  parameter int SAMPLE_W     = 24,
  parameter int WINDOW       = 4800,
  parameter int HOLD_UPDATES = 25,
  parameter int DECAY_SHIFT  = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  volume_meter_ctrl_if.slave bus
);

  localparam int CNT_W  = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int HOLD_W = $clog2(HOLD_UPDATES + 1) > 0 ? $clog2(HOLD_UPDATES + 1) : 1;
  localparam logic [SAMPLE_W-1:0] POS_FS = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] NEG_FS = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, PUB} state_t;

  state_t              state_q, state_d;
  logic [SAMPLE_W-1:0] accMax_q, accMax_d;
  logic [CNT_W-1:0]    winCnt_q, winCnt_d;
  logic                accClip_q, accClip_d;
  logic [SAMPLE_W-1:0] winMax_q, winMax_d;
  logic                winClip_q, winClip_d;
  logic [SAMPLE_W-1:0] level_q, level_d;
  logic [SAMPLE_W-1:0] peak_q, peak_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                clip_q, clip_d;
  logic                levelValid_q, levelValid_d;

  logic [SAMPLE_W-1:0] mag;
  logic                fullScale;
  logic                winEnd;
  logic                pubFire;
  logic [SAMPLE_W-1:0] decStep;
  logic [SAMPLE_W-1:0] decayed;
  logic [SAMPLE_W-1:0] levelNew;

  // The most-negative sample has no positive twin, so it saturates.
  always_comb begin
    mag       = bus.sample;
    fullScale = (bus.sample == NEG_FS) || (bus.sample == POS_FS);
    if (bus.sample == NEG_FS) begin
      mag = POS_FS;
    end else if (bus.sample[SAMPLE_W-1]) begin
      mag = -bus.sample;
    end
    winEnd = bus.sample_valid && (winCnt_q == CNT_W'(WINDOW - 1));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.sample_valid) state_d = ACCUM;
        ACCUM:   if (winEnd) state_d = PUB;
        PUB:     state_d = ACCUM;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pubFire = (state_q == PUB);
  end

  // Decay is at least one LSB so a small nonzero level always reaches zero.
  always_comb begin
    decStep = level_q >> DECAY_SHIFT;
    if (decStep == '0 && level_q != '0) begin
      decStep = SAMPLE_W'(1);
    end
    decayed  = level_q - decStep;
    levelNew = (winMax_q >= level_q) ? winMax_q
             : ((decayed > winMax_q) ? decayed : winMax_q);
  end

  always_comb begin
    accMax_d     = accMax_q;
    winCnt_d     = winCnt_q;
    accClip_d    = accClip_q;
    winMax_d     = winMax_q;
    winClip_d    = winClip_q;
    level_d      = level_q;
    peak_d       = peak_q;
    hold_d       = hold_q;
    clip_d       = clip_q;
    levelValid_d = 1'b0;
    if (clear) begin
      accMax_d  = '0;
      winCnt_d  = '0;
      accClip_d = 1'b0;
      winMax_d  = '0;
      winClip_d = 1'b0;
      level_d   = '0;
      peak_d    = '0;
      hold_d    = '0;
      clip_d    = 1'b0;
    end else begin
      if (bus.sample_valid) begin
        if (winEnd) begin
          winMax_d  = (accMax_q > mag) ? accMax_q : mag;
          winClip_d = accClip_q | fullScale;
          accMax_d  = '0;
          accClip_d = 1'b0;
          winCnt_d  = '0;
        end else begin
          accMax_d  = (accMax_q > mag) ? accMax_q : mag;
          accClip_d = accClip_q | fullScale;
          winCnt_d  = winCnt_q + CNT_W'(1);
        end
      end
      if (pubFire) begin
        level_d      = levelNew;
        clip_d       = winClip_q;
        levelValid_d = 1'b1;
        if (winMax_q >= peak_q) begin
          peak_d = winMax_q;
          hold_d = HOLD_W'(HOLD_UPDATES);
        end else if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end else begin
          peak_d = levelNew;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      accMax_q     <= '0;
      winCnt_q     <= '0;
      accClip_q    <= 1'b0;
      winMax_q     <= '0;
      winClip_q    <= 1'b0;
      level_q      <= '0;
      peak_q       <= '0;
      hold_q       <= '0;
      clip_q       <= 1'b0;
      levelValid_q <= 1'b0;
    end else begin
      accMax_q     <= accMax_d;
      winCnt_q     <= winCnt_d;
      accClip_q    <= accClip_d;
      winMax_q     <= winMax_d;
      winClip_q    <= winClip_d;
      level_q      <= level_d;
      peak_q       <= peak_d;
      hold_q       <= hold_d;
      clip_q       <= clip_d;
      levelValid_q <= levelValid_d;
    end
  end

  assign bus.level_out   = level_q;
  assign bus.peak_out    = peak_q;
  assign bus.clip_out    = clip_q;
  assign bus.level_valid = levelValid_q;

endmodule
